// File: rtl/prio_arb_pkg.sv
//============================================================================
// Module      : prio_arb_pkg
// Description : Shared types and helpers for the priority arbiter array.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package prio_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    // Upper bound on channel count supported by the rotate helper
    localparam int MAX_CH = 64;

    function automatic int chWidth(input int numCh);
        return (numCh > 1) ? $clog2(numCh) : 1;
    endfunction

    function automatic int prioMax(input int prioW);
        return (1 << prioW) - 1;
    endfunction

    // Index of the first set bit at or after start, wrapping at numCh
    function automatic int rrFirst(input logic [MAX_CH-1:0] cand,
                                   input int numCh,
                                   input int start);
        int         sum;
        logic [5:0] idx;
        rrFirst = 0;
        for (int k = MAX_CH - 1; k >= 0; k--) begin
            if (k < numCh) begin
                sum = start + k;
                if (sum >= numCh) sum = sum - numCh;
                idx = sum[5:0];
                if (cand[idx]) rrFirst = sum;
            end
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/prio_arb_array_if.sv
//============================================================================
// Module      : prio_arb_array_if
// Description : Configuration, request and grant-handshake bundle.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

interface prio_arb_array_if
    import prio_arb_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int PRIO_W = 2
);
    localparam int CH_W = chWidth(NUM_CH);

    logic [NUM_CH-1:0]        we;
    logic [PRIO_W-1:0]        prio_in;
    logic [NUM_CH*PRIO_W-1:0] prio_out;
    logic [NUM_CH-1:0]        req;
    logic                     gnt_valid;
    logic                     gnt_ready;
    logic [CH_W-1:0]          gnt_id;
    logic [PRIO_W-1:0]        gnt_prio;

    modport master (
        output we, prio_in, req, gnt_ready,
        input  prio_out, gnt_valid, gnt_id, gnt_prio
    );

    modport slave (
        input  we, prio_in, req, gnt_ready,
        output prio_out, gnt_valid, gnt_id, gnt_prio
    );

endinterface

`default_nettype wire

// File: rtl/prio_entry.sv
//============================================================================
// Module      : prio_entry
// Description : One channel's priority register plus optional age counter
//               (age counter present only when PRIO_AGING_EN is defined).
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module prio_entry
    import prio_arb_pkg::*;
#(
    parameter int PRIO_W    = 2,
    parameter int AGE_W     = 4,
    parameter int AGE_LIMIT = 15
) (
    input  wire logic              clk,
    input  wire logic              reset,
    input  wire logic              i_we,
    input  wire logic [PRIO_W-1:0] i_prioIn,
    input  wire logic              i_req,
    input  wire logic              i_hsHit,
    output logic      [PRIO_W-1:0] o_prioStored,
    output logic      [PRIO_W-1:0] o_prioEff
);

    logic [PRIO_W-1:0] r_prio;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_prio <= '0;
        else if (i_we) r_prio <= i_prioIn;
    end

    assign o_prioStored = r_prio;

`ifdef PRIO_AGING_EN
    logic [AGE_W-1:0] r_age;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_age <= '0;
        end else if (!i_req || i_hsHit) begin
            r_age <= '0;
        end else if (r_age != {AGE_W{1'b1}}) begin
            r_age <= r_age + 1'b1;
        end
    end

    // Starved channels compete at top urgency; the stored value is untouched
    assign o_prioEff = (r_age >= AGE_W'(AGE_LIMIT)) ? PRIO_W'(prioMax(PRIO_W)) : r_prio;
`else
    logic w_unused;
    assign w_unused  = &{1'b0, i_req, i_hsHit, AGE_W[0], AGE_LIMIT[0]};
    assign o_prioEff = r_prio;
`endif

endmodule

`default_nettype wire

// File: rtl/prio_arb_array.sv
//============================================================================
// Module      : prio_arb_array
// Description : Priority register file with max-priority round-robin
//               arbiter and valid/ready grant. Optional aging: PRIO_AGING_EN.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module prio_arb_array
    import prio_arb_pkg::*;
#(
    parameter int NUM_CH    = 8,
    parameter int PRIO_W    = 2,
    parameter int AGE_W     = 4,
    parameter int AGE_LIMIT = 15
) (
    input wire logic         clk,
    input wire logic         reset,
    prio_arb_array_if.slave  bus
);

    localparam int CH_W = chWidth(NUM_CH);

    state_t                   r_state;
    logic                     r_gntValid;
    logic [CH_W-1:0]          r_gntId;
    logic [PRIO_W-1:0]        r_gntPrio;
    logic [CH_W-1:0]          r_rrPtr;

    logic [PRIO_W-1:0]        w_prioStored [NUM_CH];
    logic [PRIO_W-1:0]        w_prioEff    [NUM_CH];
    logic [NUM_CH*PRIO_W-1:0] w_prioFlat;
    logic [PRIO_W-1:0]        w_maxPrio;
    logic [NUM_CH-1:0]        w_cand;
    logic [CH_W-1:0]          w_winner;
    logic [CH_W-1:0]          w_rrNext;
    logic                     w_hs;

    assign w_hs = r_gntValid && bus.gnt_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_entry
        prio_entry #(
            .PRIO_W    (PRIO_W),
            .AGE_W     (AGE_W),
            .AGE_LIMIT (AGE_LIMIT)
        ) u_entry (
            .clk          (clk),
            .reset        (reset),
            .i_we         (bus.we[i]),
            .i_prioIn     (bus.prio_in),
            .i_req        (bus.req[i]),
            .i_hsHit      (w_hs && (r_gntId == CH_W'(i))),
            .o_prioStored (w_prioStored[i]),
            .o_prioEff    (w_prioEff[i])
        );
    end

    always_comb begin
        w_prioFlat = '0;
        w_maxPrio  = '0;
        w_cand     = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_prioFlat[i*PRIO_W +: PRIO_W] = w_prioStored[i];
            if (bus.req[i] && (w_prioEff[i] > w_maxPrio)) w_maxPrio = w_prioEff[i];
        end
        for (int i = 0; i < NUM_CH; i++) begin
            w_cand[i] = bus.req[i] && (w_prioEff[i] == w_maxPrio);
        end
    end

    if (NUM_CH == 1) begin : g_single
        logic w_unused;
        assign w_unused = &{1'b0, w_cand, r_rrPtr};
        assign w_winner = '0;
        assign w_rrNext = '0;
    end else begin : g_multi
        assign w_winner = CH_W'(rrFirst(MAX_CH'(w_cand), NUM_CH, int'(r_rrPtr)));
        assign w_rrNext = (r_gntId == CH_W'(NUM_CH - 1)) ? '0 : r_gntId + 1'b1;
    end

    // Winner is taken from pre-write register values, so same-cycle writes
    // only affect the next arbitration.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_gntValid <= 1'b0;
            r_gntId    <= '0;
            r_gntPrio  <= '0;
            r_rrPtr    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|bus.req) begin
                        r_gntId    <= w_winner;
                        r_gntPrio  <= w_prioStored[w_winner];
                        r_gntValid <= 1'b1;
                        r_state    <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_hs) begin
                        r_rrPtr    <= w_rrNext;
                        r_gntValid <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.prio_out  = w_prioFlat;
    assign bus.gnt_valid = r_gntValid;
    assign bus.gnt_id    = r_gntId;
    assign bus.gnt_prio  = r_gntPrio;

endmodule

`default_nettype wire

// File: tb/tb_prio_arb_array.sv
//============================================================================
// Module      : tb_prio_arb_array
// Description : Directed self-checking bench with expected-grant scoreboard.
//               Aging scenario selected by PRIO_AGING_EN.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_prio_arb_array;
    import prio_arb_pkg::*;

    localparam int NUM_CH    = 8;
    localparam int PRIO_W    = 2;
    localparam int AGE_W     = 4;
    localparam int AGE_LIMIT = 3;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    prio_arb_array_if #(.NUM_CH(NUM_CH), .PRIO_W(PRIO_W)) bus ();

    prio_arb_array #(
        .NUM_CH    (NUM_CH),
        .PRIO_W    (PRIO_W),
        .AGE_W     (AGE_W),
        .AGE_LIMIT (AGE_LIMIT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [2:0] id;
        logic [1:0] prio;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pushExp(input int id, input int prio);
        exp_t e;
        e.id   = 3'(id);
        e.prio = 2'(prio);
        sbq.push_back(e);
    endtask

    task automatic waitValid(input string tag, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (bus.gnt_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            total++;
            bad++;
            $error("FAIL %s_timeout observed=no grant expected=grant within 20 cycles", tag);
        end
    endtask

    task automatic consumeGrant(input string tag);
        bit   ok;
        exp_t e;
        waitValid(tag, ok);
        if (ok) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $error("FAIL %s_unexpected observed=grant id %0d expected=no grant", tag, bus.gnt_id);
            end else begin
                e = sbq.pop_front();
                check({tag, "_id"},   32'(bus.gnt_id),   32'(e.id));
                check({tag, "_prio"}, 32'(bus.gnt_prio), 32'(e.prio));
            end
        end
    endtask

    initial begin
        bus.we        = '0;
        bus.prio_in   = '0;
        bus.req       = '0;
        bus.gnt_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(bus.gnt_valid), 32'd0);
        check("rst_id",    32'(bus.gnt_id),    32'd0);
        check("rst_prio",  32'(bus.gnt_prio),  32'd0);
        check("rst_prio_out", 32'(bus.prio_out), 32'h0);
        reset = 1'b1;

        // 1: broadcast write, idle without requests
        bus.we = 8'hFF; bus.prio_in = 2'd2;
        @(negedge clk);
        bus.we = '0;
        check("t1_prio_out", 32'(bus.prio_out), 32'hAAAA);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t1_idle_valid", 32'(bus.gnt_valid), 32'd0);
        end

        // 2: ch3 highest priority among requesters 1 and 3
        bus.we = 8'h08; bus.prio_in = 2'd3;
        @(negedge clk);
        bus.we = 8'hF7; bus.prio_in = 2'd1;
        @(negedge clk);
        bus.we = '0;
        check("t2_prio_out", 32'(bus.prio_out), 32'h55D5);
        bus.req = 8'h0A;
        pushExp(3, 3);
        @(negedge clk);
        check("t2_latency", 32'(bus.gnt_valid), 32'd1);
        consumeGrant("t2");
        bus.gnt_ready = 1'b1;
        bus.req = '0;
        @(negedge clk);
        bus.gnt_ready = 1'b0;
        check("t2_release", 32'(bus.gnt_valid), 32'd0);

        // 3: equal priorities, round-robin with wrap
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        bus.we = 8'hFF; bus.prio_in = 2'd2;
        @(negedge clk);
        bus.we = '0;
        bus.gnt_ready = 1'b1;
        bus.req = 8'hFF;
        for (int k = 0; k < 9; k++) pushExp(k % NUM_CH, 2);
        for (int k = 0; k < 9; k++) begin
            consumeGrant("t3");
            @(negedge clk);
        end
        bus.req = '0;
        bus.gnt_ready = 1'b0;
        @(negedge clk);

        // 4: stalled grant with req drop and rewrite of the granted channel
        bus.req = 8'h20;
        pushExp(5, 2);
        consumeGrant("t4");
        for (int k = 0; k < 5; k++) begin
            bus.req = '0;
            bus.we = 8'h20; bus.prio_in = 2'd3;
            @(negedge clk);
            check("t4_hold_valid", 32'(bus.gnt_valid), 32'd1);
            check("t4_hold_id",    32'(bus.gnt_id),    32'd5);
            check("t4_hold_prio",  32'(bus.gnt_prio),  32'd2);
        end
        bus.we = '0;
        bus.gnt_ready = 1'b1;
        @(negedge clk);
        bus.gnt_ready = 1'b0;
        check("t4_idle", 32'(bus.gnt_valid), 32'd0);
        check("t4_written", 32'(bus.prio_out[11:10]), 32'd3);

        // 5: asynchronous reset mid-grant, round-robin pointer cleared
        bus.req = 8'h01;
        pushExp(0, 2);
        consumeGrant("t5");
        bus.req = '0;
        #2 reset = 1'b0;
        #1;
        check("t5_async_valid", 32'(bus.gnt_valid), 32'd0);
        check("t5_async_prio_out", 32'(bus.prio_out), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        bus.req = 8'hC1;
        pushExp(0, 0);
        consumeGrant("t5_rrptr");
        bus.gnt_ready = 1'b1;
        bus.req = '0;
        @(negedge clk);
        bus.gnt_ready = 1'b0;
        check("t5_sb_empty", 32'(sbq.size()), 32'd0);

        // 6: low-priority ch0 against persistent urgent ch7
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        bus.we = 8'h80; bus.prio_in = 2'd3;
        @(negedge clk);
        bus.we = '0;
        bus.gnt_ready = 1'b1;
        bus.req = 8'h81;
`ifdef PRIO_AGING_EN
        begin
            bit ok;
            bit seen0;
            seen0 = 1'b0;
            for (int g = 0; g < AGE_LIMIT + 2; g++) begin
                waitValid("t6_aging", ok);
                if (ok) begin
                    check("t6_legal_id", 32'((bus.gnt_id == 3'd0) || (bus.gnt_id == 3'd7)), 32'd1);
                    if (bus.gnt_id == 3'd0) seen0 = 1'b1;
                end
                @(negedge clk);
            end
            check("t6_aged_grant", 32'(seen0), 32'd1);
        end
`else
        for (int g = 0; g < 8; g++) pushExp(7, 3);
        for (int g = 0; g < 8; g++) begin
            consumeGrant("t6_no_aging");
            @(negedge clk);
        end
`endif
        bus.req = '0;
        bus.gnt_ready = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
